// File: rtl/alu_nibble_sequencer.sv
// Sequential initiator for a 4-bit ALU slice: splits one wide operation into
// nibbles, ripples the carry slice to slice and returns the assembled result.
module alu_nibble_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_m1,
  input  logic                   req_m0,
  input  logic [4*NIBBLES-1:0]   req_a,
  input  logic [4*NIBBLES-1:0]   req_b,
  input  logic                   req_cin,
  output logic                   alu_m1,
  output logic                   alu_m0,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  input  logic [3:0]             alu_f,
  input  logic                   alu_cout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_f,
  output logic                   rsp_cout,
  output logic                   busy
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned OPW   = W - 4;
  localparam int unsigned IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  // Only the upper slices need latching; slice 0 goes straight to the ALU.
  logic [OPW-1:0]     a_q, a_d;
  logic [OPW-1:0]     b_q, b_d;
  logic               alu_m1_q, alu_m1_d;
  logic               alu_m0_q, alu_m0_d;
  logic [3:0]         alu_a_q, alu_a_d;
  logic [3:0]         alu_b_q, alu_b_d;
  logic               alu_cin_q, alu_cin_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [W-1:0]       rsp_f_q, rsp_f_d;
  logic               rsp_cout_q, rsp_cout_d;

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_m1_d    = alu_m1_q;
    alu_m0_d    = alu_m0_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_f_d     = rsp_f_q;
    rsp_cout_d  = rsp_cout_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d       = req_a[W-1:4];
          b_d       = req_b[W-1:4];
          alu_m1_d  = req_m1;
          alu_m0_d  = req_m0;
          alu_a_d   = req_a[3:0];
          alu_b_d   = req_b[3:0];
          alu_cin_d = req_cin;
          idx_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(NIBBLES); i++) begin
          if (idx_q == IDX_W'(i)) rsp_f_d[4*i +: 4] = alu_f;
        end
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          rsp_cout_d  = alu_cout;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d     = idx_q + IDX_W'(1);
          alu_cin_d = alu_cout;
          // Present slice idx+1; latched slice i sits at a_q[4*(i-1)].
          for (int i = 1; i < int'(NIBBLES); i++) begin
            if (idx_q == IDX_W'(i - 1)) begin
              alu_a_d = a_q[4*(i-1) +: 4];
              alu_b_d = b_q[4*(i-1) +: 4];
            end
          end
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_m1_q    <= 1'b0;
      alu_m0_q    <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_f_q     <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_m1_q    <= alu_m1_d;
      alu_m0_q    <= alu_m0_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_f_q     <= rsp_f_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign alu_m1    = alu_m1_q;
  assign alu_m0    = alu_m0_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: an adder stands in for the ALU, and results
// are checked against whole-width arithmetic.
module tb_alu_nibble_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_m1, req_m0, req_cin;
  logic [W-1:0] req_a, req_b;
  logic         alu_m1, alu_m0, alu_cin, alu_cout;
  logic [3:0]   alu_a, alu_b, alu_f;
  logic         rsp_valid, rsp_ready, rsp_cout, busy;
  logic [W-1:0] rsp_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ALU stand-in: plain 4-bit add with carry, mode ignored
  assign {alu_cout, alu_f} = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);

  alu_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_m1(req_m1), .req_m0(req_m0), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_m1(alu_m1), .alu_m0(alu_m0), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_cout(rsp_cout),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic m1, input logic m0, input logic cin);
    req_a = a; req_b = b; req_m1 = m1; req_m0 = m0; req_cin = cin;
    req_valid = 1'b1;
    chk("req_ready_before_accept", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_slices(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic m1, input logic m0, input logic cin);
    logic       c;
    logic [3:0] sa, sb;
    logic [4:0] s;
    c = cin;
    for (int k = 0; k < int'(N); k++) begin
      sa = a[4*k +: 4];
      sb = b[4*k +: 4];
      chk("alu_a_slice", 64'(alu_a), 64'(sa));
      chk("alu_b_slice", 64'(alu_b), 64'(sb));
      chk("alu_cin_slice", 64'(alu_cin), 64'(c));
      chk("alu_m1_run", 64'(alu_m1), 64'(m1));
      chk("alu_m0_run", 64'(alu_m0), 64'(m0));
      chk("req_ready_run", 64'(req_ready), 64'd0);
      chk("busy_run", 64'(busy), 64'd1);
      chk("rsp_valid_run", 64'(rsp_valid), 64'd0);
      s = 5'(sa) + 5'(sb) + 5'(c);
      c = s[4];
      step();
    end
  endtask

  task automatic check_rsp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] r;
    r = ref_sum(a, b, cin);
    chk("rsp_valid_done", 64'(rsp_valid), 64'd1);
    chk("rsp_f", 64'(rsp_f), 64'(r[W-1:0]));
    chk("rsp_cout", 64'(rsp_cout), 64'(r[W]));
    chk("busy_done", 64'(busy), 64'd1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
    chk("req_ready_after_hs", 64'(req_ready), 64'd1);
    chk("busy_after_hs", 64'(busy), 64'd0);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic m1, input logic m0, input logic cin);
    start_op(a, b, m1, m0, cin);
    run_slices(a, b, m1, m0, cin);
    check_rsp(a, b, cin);
    finish_rsp();
  endtask

  initial begin
    logic [W-1:0] ra, rb, kf, ba[2], bb[2];
    logic         rm1, rm0, rc, kc;
    int           acc_cyc[2];
    int           n_acc, n_rsp;
    logic         pending;
    logic [W:0]   r;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_m1 = 1'b0; req_m0 = 1'b0; req_cin = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_f", 64'(rsp_f), 64'd0);
    chk("reset_alu_bus", 64'({alu_m1, alu_m0, alu_a, alu_b, alu_cin}), 64'd0);

    // Simple carry into slice 2, then a full ripple and mode passthrough
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("op1_result", 64'({rsp_cout, rsp_f}), 64'h0_0100);
    do_op(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("op2_result", 64'({rsp_cout, rsp_f}), 64'h1_0000);
    do_op(16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0);

    // Backpressure in DONE with a request already waiting
    start_op(16'h8001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_slices(16'h8001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    check_rsp(16'h8001, 16'h7FFF, 1'b0);
    kf = rsp_f; kc = rsp_cout;
    req_a = 16'h0102; req_b = 16'h0304; req_m1 = 1'b1; req_m0 = 1'b1; req_cin = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_f", 64'(rsp_f), 64'(kf));
      chk("bp_rsp_cout", 64'(rsp_cout), 64'(kc));
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    finish_rsp();
    do_op(16'h0102, 16'h0304, 1'b1, 1'b1, 1'b1);

    // Reset while idx == 2
    start_op(16'h5555, 16'h5555, 1'b1, 1'b1, 1'b1);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_alu_bus", 64'({alu_m1, alu_m0, alu_a, alu_b, alu_cin}), 64'd0);
    step();
    chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
    chk("post_rst_result", 64'(rsp_f), 64'h0007);

    // Back-to-back with rsp_ready tied high
    ba[0] = 16'hDEAD; bb[0] = 16'hBEEF;
    ba[1] = 16'h0F0F; bb[1] = 16'hF0F1;
    n_acc = 0; n_rsp = 0;
    rsp_ready = 1'b1;
    req_a = ba[0]; req_b = bb[0]; req_cin = 1'b0; req_m1 = 1'b0; req_m0 = 1'b0;
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && n_rsp < 2; cyc++) begin
      pending = req_valid && req_ready;
      if (rsp_valid && n_rsp < 2) begin
        r = ref_sum(ba[n_rsp], bb[n_rsp], 1'b0);
        chk("b2b_rsp", 64'({rsp_cout, rsp_f}), 64'(r));
        n_rsp++;
      end
      step();
      if (pending) begin
        if (n_acc < 2) acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          req_a = ba[1]; req_b = bb[1];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("b2b_accept_count", 64'(n_acc), 64'd2);
    chk("b2b_rsp_count", 64'(n_rsp), 64'd2);
    if (n_acc >= 2) chk("b2b_accept_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'(N + 2));
    step();

    // Randomized operations
    for (int t = 0; t < 25; t++) begin
      ra = W'($urandom); rb = W'($urandom);
      rm1 = 1'($urandom); rm0 = 1'($urandom); rc = 1'($urandom);
      do_op(ra, rb, rm1, rm0, rc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
Sequential initiator for the combinational 4-bit ALU (ALU_4b). It accepts one wide operation per request over a valid/ready handshake and splits it into 4-bit slices. It drives the slices to the ALU one per cycle, least-significant first, chaining each slice's Cout into the next slice's Cin. It assembles the wide result and returns it over a second valid/ready handshake.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; operand/result width W = 4*NIBBLES; legal range 2..8

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_m1  input  1  ALU mode bit M1 for the whole operation
req_m0  input  1  ALU mode bit M0 for the whole operation
req_a  input  W  operand A
req_b  input  W  operand B
req_cin  input  1  carry-in applied to slice 0
alu_m1  output  1  to ALU M1
alu_m0  output  1  to ALU M0
alu_a  output  4  to ALU A
alu_b  output  4  to ALU B
alu_cin  output  1  to ALU Cin
alu_f  input  4  from ALU F (combinational function of alu_* outputs)
alu_cout  input  1  from ALU Cout
rsp_valid  output  1  result present
rsp_ready  input  1  consumer accepts result
rsp_f  output  W  assembled result
rsp_cout  output  1  Cout of the last slice
busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. 2-bit state register plus slice index idx (0..NIBBLES-1).
- Reset (rst=1 at an edge, any state, including mid-operation):
  - Next cycle: state=IDLE, idx=0.
  - All alu_* = 0, rsp_valid=0, rsp_f=0, rsp_cout=0, busy=0.
  - Latched operands cleared. Any in-flight operation is discarded; no partial response is produced.
- req_ready = (state==IDLE), decoded combinationally from the state register. busy = (state!=IDLE).
- IDLE, on an edge with req_valid && req_ready:
  - Latch req_a, req_b, req_m1, req_m0.
  - Register alu_a=req_a[3:0], alu_b=req_b[3:0], alu_cin=req_cin, alu_m1/alu_m0 = req mode.
  - idx=0; go to RUN.
- IDLE, no request: all outputs hold their values.
- RUN, every edge:
  - rsp_f[4*idx+3:4*idx] <= alu_f.
  - If idx < NIBBLES-1: idx <= idx+1; alu_a/alu_b <= slice idx+1 of the latched operands; alu_cin <= alu_cout.
  - If idx == NIBBLES-1: rsp_cout <= alu_cout; rsp_valid <= 1; go to DONE.
- Mode: alu_m1/alu_m0 are constant for the whole operation. The carry chain applies in every mode. The sequencer never interprets F.
- Latency: request accepted at edge 0 -> rsp_valid high after edge NIBBLES (4 cycles at default). One ALU slice per cycle.
- DONE:
  - rsp_valid=1; rsp_f/rsp_cout are stable and do not change while rsp_ready=0.
  - On an edge with rsp_valid && rsp_ready: rsp_valid <= 0 and go to IDLE. rsp_f/rsp_cout keep their values.
  - req_ready rises in the cycle after the response handshake. No overlap of request and response; throughput is one operation per NIBBLES+2 cycles minimum.
- alu_* hold their last driven values in DONE and IDLE. rsp_f bits not yet written in a new operation keep the previous operation's values until overwritten; rsp_f is only meaningful while rsp_valid=1.
- Requests asserted while req_ready=0 are ignored; the source must hold them.

Test Plan:
- Bench ALU model: F=A+B+Cin, Cout=carry out, on the alu_* ports. Request A=0x00FF, B=0x0001, cin=0 -> rsp_valid 4 cycles after acceptance, rsp_f=0x0100, rsp_cout=0.
- Full carry ripple, same bench model: A=0xFFFF, B=0x0000, cin=1 -> alu_cin=1,1,1,1 across slices; rsp_f=0x0000, rsp_cout=1.
- Slice order and mode passthrough: A=0x1234, B=0xABCD, m1=1, m0=0 -> alu_a=4,3,2,1 and alu_b=D,C,B,A on consecutive cycles; alu_m1=1, alu_m0=0 throughout; req_ready=0 and busy=1 for all of RUN.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE -> rsp_valid, rsp_f and rsp_cout stable; req_ready=0; a pending req_valid is not accepted until the cycle after the response handshake.
- Reset mid-operation: assert rst at idx=2 -> next cycle state IDLE, req_ready=1, rsp_valid=0, alu_*=0; a fresh request A=0x0003, B=0x0004 then returns rsp_f=0x0007.
- Back-to-back: two requests with rsp_ready tied 1 -> acceptance edges 6 cycles apart; both results correct.
